ucaspian_synapse: RTL

Receiving end of the axon->synapse interface. The block accepts an inclusive synapse index range (syn_start..syn_end) from the axon and walks it one entry at a time. For each entry it reads the synapse RAM (target neuron, signed weight) and emits one record per synapse to the dendrite stage over a valid/ready handshake. It also owns synapse configuration loading, configuration clearing and activity clearing.

---
 rtl/ucaspian_synapse.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/ucaspian_synapse.sv
// ucaspian_synapse: the synapse stage sits between the axon and dendrite stages.
// It accepts an inclusive synapse index range from the axon stage and walks that
// range. For each synapse it reads the synapse RAM entry, which holds a signed
// weight and a target neuron. It sends one record per synapse to the dendrite
// stage over a valid/ready handshake. This block also handles synapse
// configuration writes, the full RAM clear sweep and the activity abort.
//
// Optional build macro: UCASPIAN_SYN_SKIP_ZERO_EN. When it is defined, the walk
// skips entries whose weight is zero and emits no record for them.
//
// The handshake outputs (syn_rdy, dend_vld) are gated by enable. A handshake can
// only complete in a cycle where the FSM is allowed to act on it.
module ucaspian_synapse #(
  parameter int SYN_ADDR_W = 12,
  parameter int NEURON_W   = 8,
  parameter int WEIGHT_W   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  clear_act,
  input  logic                  clear_config,
  output logic                  clear_done,
  input  logic [SYN_ADDR_W-1:0] config_addr,
  input  logic [11:0]           config_value,
  input  logic [2:0]            config_byte,
  input  logic                  config_enable,
  input  logic                  next_step,
  output logic                  step_done,
  input  logic [SYN_ADDR_W-1:0] syn_start,
  input  logic [SYN_ADDR_W-1:0] syn_end,
  input  logic                  syn_vld,
  output logic                  syn_rdy,
  output logic [NEURON_W-1:0]   dend_addr,
  output logic [WEIGHT_W-1:0]   dend_weight,
  output logic                  dend_vld,
  input  logic                  dend_rdy
);

  localparam int DEPTH   = 2 ** SYN_ADDR_W;
  localparam int ENTRY_W = WEIGHT_W + NEURON_W;

  typedef enum logic [1:0] {IDLE, READ, EMIT} state_t;

  state_t state, state_nxt;

  logic [SYN_ADDR_W-1:0] cur, last;
  logic [ENTRY_W-1:0]    mem [DEPTH];
  logic [ENTRY_W-1:0]    rd_data;
  logic [WEIGHT_W-1:0]   held_weight;
  logic [SYN_ADDR_W-1:0] clr_cnt;
  logic                  clr_full;

  logic                  clr_any;
  logic                  accept;
  logic                  advance;
  logic                  rd_en;
  logic                  skip_entry;
  logic                  mem_we;
  logic [SYN_ADDR_W-1:0] mem_waddr;
  logic [ENTRY_W-1:0]    mem_wdata;

  // next_step is informational only, and config_value carries at most one byte.
  logic unused_inputs;
  assign unused_inputs = ^{config_value[11:8], next_step};

  assign clr_any = reset | clear_act | clear_config;
  assign accept  = syn_rdy & syn_vld;
  assign rd_en   = (state == READ) & enable & ~clr_any;

`ifdef UCASPIAN_SYN_SKIP_ZERO_EN
  assign skip_entry = (state == EMIT) && (rd_data[ENTRY_W-1:NEURON_W] == '0);
`else
  assign skip_entry = 1'b0;
`endif

  // The clear sweep owns the write port. Config writes are locked out while it runs.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = config_addr;
    mem_wdata = {held_weight, config_value[NEURON_W-1:0]};
    if (!reset) begin
      if (clear_config) begin
        mem_we    = ~clr_full;
        mem_waddr = clr_cnt;
        mem_wdata = '0;
      end else if (config_enable && config_byte == 3'd4) begin
        mem_we = 1'b1;
      end
    end
  end

  // Synapse RAM: one write port, one registered read port. When a read and a
  // write hit the same address in the same cycle, the read returns the old data.
  // NOTE: the RAM array is deliberately not reset so that it maps onto block RAM; only control state is reset.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    if (rd_en)  rd_data <= mem[cur];
  end

  // Weight holding register for the two-step config transaction.
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) held_weight <= '0;
    else if (!clear_config && config_enable && config_byte == 3'd3)
      held_weight <= config_value[WEIGHT_W-1:0];
  end

  // Clear sweep counter; it restarts from address 0 whenever clear_config drops.
  always_ff @(posedge clk) begin
    if (reset || !clear_config) begin
      clr_cnt  <= '0;
      clr_full <= 1'b0;
    end else if (!clr_full) begin
      clr_cnt <= clr_cnt + 1'b1;
      if (&clr_cnt) clr_full <= 1'b1;
    end
  end

  // clear_done: goes high one cycle after clear_act, or one cycle after the last sweep write.
  always_ff @(posedge clk) begin
    if (reset) clear_done <= 1'b0;
    else       clear_done <= clear_act | (clear_config & (clr_full | (&clr_cnt)));
  end

  // State register; reset and both clears force IDLE and drop any pending record.
  always_ff @(posedge clk) begin
    if (clr_any) state <= IDLE;
    else         state <= state_nxt;
  end

  // Walk pointers: latch the range on accept and step after each finished entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      cur  <= '0;
      last <= '0;
    end else if (accept) begin
      cur  <= syn_start;
      last <= syn_end;
    end else if (advance && cur != last) begin
      cur <= cur + 1'b1;
    end
  end

  // Next-state logic; an entry is finished when it is handshaked or skipped.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_nxt = state;
    advance   = 1'b0;
    unique case (state)
      IDLE: if (accept) state_nxt = READ;
      READ: if (enable && !clr_any) state_nxt = EMIT;
      EMIT: begin
        advance = enable & ~clr_any & (skip_entry | (dend_vld & dend_rdy));
        if (advance) state_nxt = (cur == last) ? IDLE : READ;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode; every output is forced to zero while reset or a clear is active.
  always_comb begin
    syn_rdy     = 1'b0;
    step_done   = 1'b0;
    dend_vld    = 1'b0;
    dend_addr   = '0;
    dend_weight = '0;
    if (!clr_any) begin
      unique case (state)
        IDLE: begin
          syn_rdy   = enable;
          step_done = 1'b1;
        end
        EMIT: begin
          if (!skip_entry) begin
            dend_vld    = enable;
            dend_addr   = rd_data[NEURON_W-1:0];
            dend_weight = rd_data[ENTRY_W-1:NEURON_W];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
